// File: rtl/fp16_pkg.sv
// Shared FP16 constants, pipeline stage payloads and packing helpers
// for the adder and multiplier datapaths.
package fp16_pkg;

  localparam int          EXP_W   = 5;
  localparam int          MANT_W  = 10;
  localparam int          BIAS    = 15;
  localparam int          EXP_MAX = 31;
  localparam logic [15:0] POS_INF = 16'h7C00;

  localparam int SIG_W     = MANT_W + 1;
  localparam int EXT_W     = SIG_W + 3;
  localparam int SUM_W     = EXT_W + 1;
  localparam int LZC_W     = SIG_W + 1;
  localparam int LZC_CNT_W = 4;
  localparam int NEXP_W    = 7;
  localparam int DIFF_FOLD = 13;

  localparam logic [EXP_W-1:0] EXP_ALL1 = EXP_W'(EXP_MAX);

  typedef struct packed {
    logic              sign_l;
    logic              sign_s;
    logic [EXP_W-1:0]  exp_l;
    logic [EXP_W-1:0]  exp_s;
    logic [SIG_W-1:0]  sig_l;
    logic [SIG_W-1:0]  sig_s;
    logic              special;
    logic [15:0]       special_x;
  } unpack_t;

  typedef struct packed {
    logic              sign_l;
    logic              sign_s;
    logic [EXP_W-1:0]  exp_l;
    logic [EXT_W-1:0]  sig_l;
    logic [EXT_W-1:0]  sig_s;
    logic              special;
    logic [15:0]       special_x;
  } align_t;

  // exp is two's complement so underflow past zero stays detectable
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [NEXP_W-1:0] exp;
    logic [EXT_W-1:0]  norm;
    logic              special;
    logic [15:0]       special_x;
  } norm_t;

  function automatic logic [15:0] fp16_inf(input logic sign);
    return POS_INF | {sign, 15'b0};
  endfunction

  function automatic logic [15:0] fp16_zero(input logic sign);
    return {sign, 15'b0};
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// 12-bit leading-zero counter; an all-zero input reports 12.
module fp16_lzc
  import fp16_pkg::*;
(
  input  logic [LZC_W-1:0]     value_i,
  output logic [LZC_CNT_W-1:0] count_o
);

  // scanning upward lets the highest set bit win
  always_comb begin
    count_o = LZC_CNT_W'(LZC_W);
    for (int i = 0; i < LZC_W; i++) begin
      if (value_i[i]) count_o = LZC_CNT_W'(LZC_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp16_adder.sv
// Four-stage FP16 adder/subtractor with a single global stall, subnormal
// flush, infinity clamping and round-to-nearest-even.
module fp16_adder
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] x,
  output logic        ovf
);

  logic    advance;
  logic    v1_q, v2_q, v3_q, out_valid_q;
  unpack_t s1_d, s1_q;
  align_t  s2_d, s2_q;
  norm_t   s3_d, s3_q;
  logic [15:0] x_d, x_q;
  logic        ovf_d, ovf_q;

  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign ovf       = ovf_q;

  // S1: unpack, flush specials, order by magnitude
  logic             sign_b, a_zero, b_zero, a_inf, b_inf;
  logic [14:0]      mag_a, mag_b;
  logic [SIG_W-1:0] sig_a, sig_b;

  always_comb begin
    sign_b = b[15] ^ sub;
    a_zero = (a[14:10] == '0);
    b_zero = (b[14:10] == '0);
    a_inf  = (a[14:10] == EXP_ALL1);
    b_inf  = (b[14:10] == EXP_ALL1);
    mag_a  = a_zero ? '0 : a[14:0];
    mag_b  = b_zero ? '0 : b[14:0];
    sig_a  = a_zero ? '0 : {1'b1, a[MANT_W-1:0]};
    sig_b  = b_zero ? '0 : {1'b1, b[MANT_W-1:0]};

    s1_d           = '0;
    s1_d.special   = a_inf | b_inf;
    s1_d.special_x = a_inf ? fp16_inf(a[15]) : fp16_inf(sign_b);
    if (mag_b > mag_a) begin
      s1_d.sign_l = sign_b;
      s1_d.sign_s = a[15];
      s1_d.exp_l  = b[14:10];
      s1_d.exp_s  = a[14:10];
      s1_d.sig_l  = sig_b;
      s1_d.sig_s  = sig_a;
    end else begin
      s1_d.sign_l = a[15];
      s1_d.sign_s = sign_b;
      s1_d.exp_l  = a[14:10];
      s1_d.exp_s  = b[14:10];
      s1_d.sig_l  = sig_a;
      s1_d.sig_s  = sig_b;
    end
  end

  // S2: align the smaller operand, collecting shifted-out bits as sticky
  logic [EXP_W-1:0]     diff;
  logic [2*EXT_W-3:0]   shifted;

  always_comb begin
    diff    = s1_q.exp_l - s1_q.exp_s;
    shifted = {s1_q.sig_s, {(2*EXT_W-2-SIG_W){1'b0}}} >> diff;

    s2_d           = '0;
    s2_d.sign_l    = s1_q.sign_l;
    s2_d.sign_s    = s1_q.sign_s;
    s2_d.exp_l     = s1_q.exp_l;
    s2_d.sig_l     = {s1_q.sig_l, 3'b000};
    s2_d.special   = s1_q.special;
    s2_d.special_x = s1_q.special_x;
    if (diff >= EXP_W'(DIFF_FOLD))
      s2_d.sig_s = {{(EXT_W-1){1'b0}}, |s1_q.sig_s};
    else
      s2_d.sig_s = shifted[2*EXT_W-3 -: EXT_W] | {{(EXT_W-1){1'b0}}, |shifted[EXT_W-3:0]};
  end

  // S3: add/subtract, then normalise the leading one to norm[EXT_W-1]
  logic                 eff_sub;
  logic [SUM_W-1:0]     sum;
  logic [LZC_CNT_W-1:0] lz, shl;

  fp16_lzc u_lzc (
    .value_i (sum[SUM_W-1:3]),
    .count_o (lz)
  );

  // lz==12 can only leave the guard bit set, which a shift of 11 handles
  always_comb begin
    eff_sub = s2_q.sign_l ^ s2_q.sign_s;
    sum     = eff_sub ? ({1'b0, s2_q.sig_l} - {1'b0, s2_q.sig_s})
                      : ({1'b0, s2_q.sig_l} + {1'b0, s2_q.sig_s});
    shl     = lz - 4'd1;

    s3_d           = '0;
    s3_d.special   = s2_q.special;
    s3_d.special_x = s2_q.special_x;
    s3_d.zero      = (sum == '0);
    s3_d.sign      = s3_d.zero ? (s2_q.sign_l & s2_q.sign_s) : s2_q.sign_l;
    if (lz == '0) begin
      s3_d.norm = {sum[SUM_W-1:2], |sum[1:0]};
      s3_d.exp  = {2'b00, s2_q.exp_l} + 7'd1;
    end else begin
      s3_d.norm = EXT_W'(sum << shl);
      s3_d.exp  = {2'b00, s2_q.exp_l} - {3'b000, shl};
    end
  end

  // S4: round to nearest even, then clamp and pack
  logic                  rnd_up;
  logic [SIG_W:0]        sig_r;
  logic [NEXP_W-1:0]     exp_f;
  logic [MANT_W-1:0]     mant_f;

  always_comb begin
    rnd_up = s3_q.norm[2] & (s3_q.norm[3] | s3_q.norm[1] | s3_q.norm[0]);
    sig_r  = {1'b0, s3_q.norm[EXT_W-1:3]} + {{SIG_W{1'b0}}, rnd_up};
    exp_f  = s3_q.exp + {{(NEXP_W-1){1'b0}}, sig_r[SIG_W]};
    mant_f = sig_r[SIG_W] ? sig_r[MANT_W:1] : sig_r[MANT_W-1:0];

    ovf_d = 1'b0;
    if (s3_q.special) begin
      x_d = s3_q.special_x;
    end else if (s3_q.zero) begin
      x_d = fp16_zero(s3_q.sign);
    end else if ($signed(exp_f) >= $signed(NEXP_W'(EXP_MAX))) begin
      x_d   = fp16_inf(s3_q.sign);
      ovf_d = 1'b1;
    end else if ($signed(exp_f) <= $signed(7'd0)) begin
      x_d = fp16_zero(s3_q.sign);
    end else begin
      x_d = {s3_q.sign, exp_f[EXP_W-1:0], mant_f};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      ovf_q       <= 1'b0;
    end else if (advance) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      if (v3_q) begin
        x_q   <= x_d;
        ovf_q <= ovf_d;
      end
    end
  end

  // payload registers are qualified by the valid chain, so no reset needed
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

endmodule

// File: tb/tb_fp16_adder.sv
// Randomized and directed bench for fp16_adder against an exact-integer
// reference model with an in-order expected-result queue.
module tb_fp16_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready, ovf;
  logic [15:0] a, b, x;

  int          total = 0;
  int          bad   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;
  int          bp_idx, bp_pop, lat;

  fp16_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Exact sum in units of 2^-24, then rounded to FP16 with plain integer math.
  function automatic logic [16:0] ref_add(input logic [15:0] opa, input logic [15:0] opb,
                                          input logic op_sub);
    logic   sa, sb, sign;
    int     ea, eb, p, sh, e;
    longint va, vb, s, m, q, rem, half;
    sa = opa[15];
    sb = opb[15] ^ op_sub;
    ea = int'(opa[14:10]);
    eb = int'(opb[14:10]);
    if (ea == 31) return {1'b0, sa, 5'h1F, 10'h0};
    if (eb == 31) return {1'b0, sb, 5'h1F, 10'h0};
    va = (ea == 0) ? 64'sd0 : (longint'({1'b1, opa[9:0]}) << (ea - 1));
    vb = (eb == 0) ? 64'sd0 : (longint'({1'b1, opb[9:0]}) << (eb - 1));
    s  = (sa ? -va : va) + (sb ? -vb : vb);
    if (s == 0) return {1'b0, sa & sb, 15'h0};
    sign = (s < 0);
    m    = sign ? -s : s;
    p    = 0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    e = p - 9;
    if (e < 1) return {1'b0, sign, 15'h0};
    sh = p - 10;
    q  = m >>> sh;
    if (sh > 0) begin
      half = 64'sd1 << (sh - 1);
      rem  = m & ((64'sd1 << sh) - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    if (q == 2048) begin
      q = 1024;
      e = e + 1;
    end
    if (e >= 31) return {1'b1, sign, 5'h1F, 10'h0};
    return {1'b0, sign, 5'(e), 10'(q)};
  endfunction

  function automatic logic [15:0] rand_op(input int near);
    int t, mode;
    logic [4:0] e;
    mode = int'($urandom_range(0, 15));
    t    = near + int'($urandom_range(0, 4)) - 2;
    if (t < 1) t = 1;
    if (t > 30) t = 30;
    if (mode == 0)      e = 5'd0;
    else if (mode == 1) e = 5'd31;
    else if (mode < 9)  e = 5'(t);
    else                e = 5'($urandom_range(1, 30));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("x", 32'(x), 32'(mon_e[15:0]));
          chk("ovf", 32'(ovf), 32'(mon_e[16]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(a, b, sub));
    end
  end

  task automatic run_dir(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                         input logic si, input logic [15:0] xw, input logic ow);
    @(posedge clk); #1;
    a = ai; b = bi; sub = si; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_acc"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    chk(tag, 32'(x), 32'(xw));
    chk({tag, "_ovf"}, 32'(ovf), 32'(ow));
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    run_dir("one_plus_one",  16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0);
    run_dir("one_minus_one", 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0);
    run_dir("rnd_up",        16'h3C00, 16'h1400, 1'b0, 16'h3C01, 1'b0);
    run_dir("tie_even_dn",   16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0);
    run_dir("tie_even_up",   16'h3C00, 16'h1600, 1'b0, 16'h3C02, 1'b0);
    run_dir("overflow",      16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1);
    run_dir("subnorm_flush", 16'h0001, 16'h3C00, 1'b0, 16'h3C00, 1'b0);
    run_dir("inf_minus_inf", 16'h7C00, 16'hFC00, 1'b0, 16'h7C00, 1'b0);
    run_dir("nan_clamp",     16'h7E00, 16'h3C00, 1'b0, 16'h7C00, 1'b0);
    run_dir("neg_zero",      16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0);

    // eight-op stream with a three-cycle consumer stall while results are out
    bp_idx = 0;
    bp_pop = 0;
    for (int cyc = 0; cyc < 60 && bp_pop < 8; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (bp_idx < 8);
      a = 16'h3C00 + 16'(bp_idx); b = 16'h0000; sub = 1'b0;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        if (exp_q.size() != 0) chk("bp_hold", 32'(x), 32'(exp_q[0][15:0]));
      end
      if (in_valid && in_ready) bp_idx++;
      if (out_valid && out_ready) bp_pop++;
    end
    chk("bp_count", 32'(bp_pop), 32'd8);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_extra", 32'(out_valid), 32'd0);

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      sub       = 1'($urandom);
      a         = rand_op(int'($urandom_range(1, 30)));
      b         = ($urandom_range(0, 9) == 0) ? (a ^ {sub ? 1'b0 : 1'b1, 15'h0})
                                               : rand_op(int'(a[14:10]));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    // three ops in flight with the first one stalled at the output
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0; b = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      a = 16'h4400 + 16'(i << 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("rst_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_x", 32'(x), 32'd0);
    chk("rst_mid_ovf", 32'(ovf), 32'd0);
    exp_q.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int n = 0; n < 8; n++) begin
      chk("rst_stale", 32'(out_valid), 32'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
